// File: rtl/fir_tap_buffer.sv
// FIR coefficient buffer: loads NB_TAPS taps from a valid/ready stream, then holds them.
// Optional macro FIR_TAP_BUFFER_REVERSE_EN stores arrival k in slot NB_TAPS-1-k.
module fir_tap_buffer #(
  parameter int unsigned NB_TAPS    = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic                          h_valid_i,
  output logic                          h_ready_o,
  input  logic [DATA_WIDTH-1:0]         h_data_i,
  output logic [NB_TAPS*DATA_WIDTH-1:0] taps_o,
  output logic                          taps_valid_o,
  output logic                          done_o
);

  localparam int unsigned CntW = $clog2(NB_TAPS);

  typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] taps_q [NB_TAPS];
  logic                  done_q;
  logic                  taps_valid_q;
  logic                  last_tap;
  logic [CntW-1:0]       slot;

  assign last_tap = (cnt_q == CntW'(NB_TAPS - 1));

`ifdef FIR_TAP_BUFFER_REVERSE_EN
  assign slot = CntW'(NB_TAPS - 1) - cnt_q;
`else
  assign slot = cnt_q;
`endif

  assign h_ready_o    = (state_q == StLoad);
  assign taps_valid_o = taps_valid_q;
  assign done_o       = done_q;

  always_comb begin
    taps_o = '0;
    for (int unsigned i = 0; i < NB_TAPS; i++) begin
      taps_o[i*DATA_WIDTH +: DATA_WIDTH] = taps_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      taps_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NB_TAPS; i++) taps_q[i] <= '0;
    end else if (clear_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      taps_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NB_TAPS; i++) taps_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StLoad;
            cnt_q   <= '0;
          end
        end
        // start_i is deliberately ignored here; only handshakes advance the load.
        StLoad: begin
          if (h_valid_i) begin
            for (int unsigned i = 0; i < NB_TAPS; i++) begin
              if (slot == CntW'(i)) taps_q[i] <= h_data_i;
            end
            if (last_tap) begin
              state_q      <= StHold;
              cnt_q        <= '0;
              done_q       <= 1'b1;
              taps_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StHold: begin
          if (start_i) begin
            state_q      <= StLoad;
            cnt_q        <= '0;
            taps_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= StIdle;
          cnt_q        <= '0;
          taps_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
